// File: rtl/zero_pad_stream.sv
// Zero-padding stage ahead of the 3x3 convolution: wraps each IMG_H x IMG_W raster frame
// in a PAD-wide border of zero pixels, with valid/ready handshakes on both sides.
module zero_pad_stream #(
   parameter int IMG_W = 512,
   parameter int IMG_H = 512,
   parameter int PAD   = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_valid,
   input  logic [7:0] i_x,
   output logic       o_ready,
   input  logic       i_ready,
   output logic       o_valid,
   output logic [7:0] o_y,
   output logic       o_frame_done
);

   localparam int STREAM_W = IMG_W + 2 * PAD;
   localparam int STREAM_H = IMG_H + 2 * PAD;
   localparam int CW       = $clog2(STREAM_W);
   localparam int RW       = $clog2(STREAM_H);

   localparam logic [CW-1:0] COL_LAST     = CW'(STREAM_W - 1);
   localparam logic [CW-1:0] COL_LEFT_END = CW'(PAD - 1);
   localparam logic [CW-1:0] COL_BODY_END = CW'(PAD + IMG_W - 1);
   localparam logic [RW-1:0] ROW_TOP_END  = RW'(PAD - 1);
   localparam logic [RW-1:0] ROW_BODY_END = RW'(PAD + IMG_H - 1);
   localparam logic [RW-1:0] ROW_LAST     = RW'(STREAM_H - 1);

   typedef enum logic [2:0] {
      S_TOP,
      S_LEFT,
      S_BODY,
      S_RIGHT,
      S_BOT
   } state_t;

   state_t        state, state_nx;
   logic [CW-1:0] col, col_nx;
   logic [RW-1:0] row, row_nx;
   logic          last_nx;
   logic          o_last;
   logic          advance;
   logic          emit;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_TOP;
         col   <= '0;
         row   <= '0;
      end else begin
         state <= state_nx;
         col   <= col_nx;
         row   <= row_nx;
      end
   end

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_nx = state;
      col_nx   = col;
      row_nx   = row;
      last_nx  = 1'b0;
      if (emit) begin
         col_nx = col + CW'(1);
         case (state)
            S_TOP: begin
               if (col == COL_LAST) begin
                  col_nx   = '0;
                  row_nx   = row + RW'(1);
                  state_nx = (row == ROW_TOP_END) ? S_LEFT : S_TOP;
               end
            end
            S_LEFT: begin
               if (col == COL_LEFT_END) state_nx = S_BODY;
            end
            S_BODY: begin
               if (col == COL_BODY_END) state_nx = S_RIGHT;
            end
            S_RIGHT: begin
               if (col == COL_LAST) begin
                  col_nx   = '0;
                  row_nx   = row + RW'(1);
                  state_nx = (row == ROW_BODY_END) ? S_BOT : S_LEFT;
               end
            end
            S_BOT: begin
               if (col == COL_LAST) begin
                  col_nx = '0;
                  if (row == ROW_LAST) begin
                     row_nx   = '0;
                     state_nx = S_TOP;
                     last_nx  = 1'b1;
                  end else begin
                     row_nx = row + RW'(1);
                  end
               end
            end
            default: state_nx = S_TOP;
         endcase
      end
   end

   // Border states emit without waiting on upstream; only the body pixels need i_valid.
   always_comb begin
      advance = ~o_valid | i_ready;
      o_ready = advance & (state == S_BODY);
      emit    = advance & ((state != S_BODY) | i_valid);
   end

   // o_last marks that the output register holds the final pixel of the padded frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         o_valid      <= 1'b0;
         o_y          <= '0;
         o_last       <= 1'b0;
         o_frame_done <= 1'b0;
      end else begin
         o_frame_done <= o_valid & i_ready & o_last;
         if (advance) begin
            o_valid <= emit;
            o_last  <= last_nx;
            if (emit) o_y <= (state == S_BODY) ? i_x : 8'd0;
         end
      end
   end

endmodule

// File: tb/tb_zero_pad_stream.sv
// Bench for zero_pad_stream: random handshakes, a padded-frame reference model feeding a
// scoreboard queue, and a monitor that checks every accepted beat and frame-done pulse.
module tb_zero_pad_stream;

   localparam int W      = 4;
   localparam int H      = 3;
   localparam int P      = 1;
   localparam int SW     = W + 2 * P;
   localparam int SH     = H + 2 * P;
   localparam int FRAME  = SW * SH;
   localparam int PREFIX = P * SW + P;
   localparam int W2     = 2;
   localparam int H2     = 1;
   localparam int P2     = 2;
   localparam int FRAME2 = (W2 + 2 * P2) * (H2 + 2 * P2);
   localparam int PREFIX2 = P2 * (W2 + 2 * P2) + P2;

   typedef struct packed {
      logic [7:0] y;
      logic       last;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       i_valid;
   logic [7:0] i_x;
   logic       o_ready;
   logic       i_ready;
   logic       o_valid;
   logic [7:0] o_y;
   logic       o_frame_done;

   logic       reset_b;
   logic       b_i_valid;
   logic [7:0] b_i_x;
   logic       b_o_ready;
   logic       b_i_ready;
   logic       b_o_valid;
   logic [7:0] b_o_y;
   logic       b_o_frame_done;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t exp_q[$];
   exp_t exp_b[$];
   logic [7:0] in_q[$];
   int   beats, frames, beats_b, frames_b;
   int   first_beat_cyc, last_beat_cyc;
   int   cyc = 0;
   int   valid_pct = 100;
   int   ready_pct = 100;

   always #5 clk = ~clk;

   zero_pad_stream #(.IMG_W(W), .IMG_H(H), .PAD(P)) dut (
      .clk          (clk),
      .reset        (reset),
      .i_valid      (i_valid),
      .i_x          (i_x),
      .o_ready      (o_ready),
      .i_ready      (i_ready),
      .o_valid      (o_valid),
      .o_y          (o_y),
      .o_frame_done (o_frame_done)
   );

   zero_pad_stream #(.IMG_W(W2), .IMG_H(H2), .PAD(P2)) dut_b (
      .clk          (clk),
      .reset        (reset_b),
      .i_valid      (b_i_valid),
      .i_x          (b_i_x),
      .o_ready      (b_o_ready),
      .i_ready      (b_i_ready),
      .o_valid      (b_o_valid),
      .o_y          (b_o_y),
      .o_frame_done (b_o_frame_done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: a padded frame is the raster with zeros wherever (r,c) lies outside the image.
   task automatic push_frame(input int sel, input int w, input int h, input int pad,
                             input logic [7:0] pix[$]);
      int   sw = w + 2 * pad;
      int   sh = h + 2 * pad;
      exp_t e;
      for (int r = 0; r < sh; r++) begin
         for (int c = 0; c < sw; c++) begin
            e.y    = (r >= pad && r < pad + h && c >= pad && c < pad + w) ?
                     pix[(r - pad) * w + (c - pad)] : 8'd0;
            e.last = (r == sh - 1) && (c == sw - 1);
            if (sel == 0) exp_q.push_back(e);
            else          exp_b.push_back(e);
         end
      end
      if (sel == 0) foreach (pix[i]) in_q.push_back(pix[i]);
   endtask

   // A new frame always opens with its top border rows and the first left border, input or not.
   task automatic push_prefix(input int sel, input int w, input int pad);
      exp_t e;
      e.y    = 8'd0;
      e.last = 1'b0;
      for (int k = 0; k < pad * (w + 2 * pad) + pad; k++) begin
         if (sel == 0) exp_q.push_back(e);
         else          exp_b.push_back(e);
      end
   endtask

   task automatic wait_beats(input int target, input int budget, input string name);
      int n = 0;
      while (beats < target && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      check(name, beats, target);
   endtask

   task automatic assert_reset();
      @(negedge clk);
      #1;
      reset = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic release_reset();
      @(negedge clk);
      #1;
      reset = 1'b1;
   endtask

   // Upstream driver: offers the head of in_q with valid_pct probability, random downstream ready.
   initial begin : drv_a
      logic took;
      i_valid = 1'b0;
      i_x     = 8'd0;
      i_ready = 1'b0;
      forever begin
         @(negedge clk);
         took = i_valid & o_ready & reset;
         @(posedge clk);
         #1;
         if (!reset) in_q.delete();
         else if (took && in_q.size() > 0) void'(in_q.pop_front());
         i_ready = int'($urandom_range(99)) < ready_pct;
         i_valid = (in_q.size() > 0) && (int'($urandom_range(99)) < valid_pct);
         i_x     = (in_q.size() > 0) ? in_q[0] : 8'($urandom);
      end
   end

   initial begin : mon_a
      exp_t       e;
      logic       pend = 1'b0;
      logic       prev_stall = 1'b0;
      logic [7:0] prev_y = 8'd0;
      beats  = 0;
      frames = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset) begin
            exp_q.delete();
            pend       = 1'b0;
            prev_stall = 1'b0;
            beats      = 0;
            frames     = 0;
         end else begin
            check("frame_done", o_frame_done, pend);
            if (o_frame_done) frames++;
            if (prev_stall) begin
               check("stall_valid", o_valid, 1);
               check("stall_y", o_y, prev_y);
            end
            pend = 1'b0;
            if (o_valid && i_ready) begin
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL overrun: unexpected beat y=%0d at %0t", o_y, $time);
               end else begin
                  e = exp_q.pop_front();
                  check("beat_y", o_y, e.y);
                  pend = e.last;
               end
               beats++;
               if (beats == 1) first_beat_cyc = cyc;
               last_beat_cyc = cyc;
            end
            prev_stall = o_valid && !i_ready;
            prev_y     = o_y;
         end
      end
   end

   initial begin : mon_b
      exp_t e;
      logic pend = 1'b0;
      beats_b  = 0;
      frames_b = 0;
      forever begin
         @(negedge clk);
         if (reset_b) begin
            check("b_frame_done", b_o_frame_done, pend);
            if (b_o_frame_done) frames_b++;
            pend = 1'b0;
            if (b_o_valid && b_i_ready) begin
               if (exp_b.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL b_overrun: unexpected beat y=%0d at %0t", b_o_y, $time);
               end else begin
                  e = exp_b.pop_front();
                  check("b_beat_y", b_o_y, e.y);
                  pend = e.last;
               end
               beats_b++;
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [7:0] pix[$];
      logic [7:0] pix_b[$];
      int         prev_beats;
      int         held_beats;
      int         n;
      int         idx;
      logic       took;

      reset     = 1'b0;
      reset_b   = 1'b0;
      b_i_valid = 1'b0;
      b_i_x     = 8'd0;
      b_i_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_valid", o_valid, 0);
      check("rst_y", o_y, 0);
      check("rst_frame_done", o_frame_done, 0);
      check("rst_ready", o_ready, 0);

      // Full-throughput frame 1..12 followed by the next frame's leading zeros.
      pix.delete();
      for (int i = 1; i <= W * H; i++) pix.push_back(8'(i));
      valid_pct = 100;
      ready_pct = 100;
      release_reset();
      push_frame(0, W, H, P, pix);
      push_prefix(0, W, P);
      wait_beats(FRAME, 300, "t1_beats");
      check("t1_contiguous", last_beat_cyc - first_beat_cyc, FRAME - 1);
      wait_beats(FRAME + PREFIX, 300, "t1_prefix_beats");
      repeat (4) @(negedge clk);
      #1;
      check("t1_frames", frames, 1);
      check("t1_idle_valid", o_valid, 0);
      check("t1_idle_ready", o_ready, 1);
      check("t1_beats_stop", beats, FRAME + PREFIX);

      // No input at all: top row plus the first left border, then idle waiting on upstream.
      assert_reset();
      release_reset();
      push_prefix(0, W, P);
      wait_beats(PREFIX, 100, "t2_beats");
      repeat (5) @(negedge clk);
      #1;
      check("t2_beats_stop", beats, PREFIX);
      check("t2_idle_valid", o_valid, 0);
      check("t2_idle_ready", o_ready, 1);

      // Three random frames back-to-back under random valid and ready.
      assert_reset();
      valid_pct = 50;
      ready_pct = 50;
      release_reset();
      for (int f = 0; f < 3; f++) begin
         pix.delete();
         for (int i = 0; i < W * H; i++) pix.push_back(8'($urandom));
         push_frame(0, W, H, P, pix);
      end
      push_prefix(0, W, P);
      wait_beats(3 * FRAME + PREFIX, 5000, "t3_beats");
      repeat (4) @(negedge clk);
      #1;
      check("t3_frames", frames, 3);
      check("t3_exp_left", exp_q.size(), 0);

      // Downstream stall right after the first beat.
      assert_reset();
      valid_pct = 100;
      ready_pct = 100;
      release_reset();
      pix.delete();
      for (int i = 0; i < W * H; i++) pix.push_back(8'($urandom_range(1, 255)));
      push_frame(0, W, H, P, pix);
      push_prefix(0, W, P);
      wait_beats(1, 50, "t4_first_beat");
      ready_pct = 0;
      @(posedge clk);
      #2;
      held_beats = beats;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         #1;
         check("t4_held_valid", o_valid, 1);
         check("t4_held_y", o_y, 0);
         check("t4_held_ready", o_ready, 0);
      end
      check("t4_no_beats", beats, held_beats);
      check("t4_in_untouched", in_q.size(), W * H);
      ready_pct = 100;
      wait_beats(FRAME + PREFIX, 300, "t4_beats");
      repeat (3) @(negedge clk);
      #1;
      check("t4_frames", frames, 1);

      // Reset in the middle of the body, then a fresh full frame.
      assert_reset();
      release_reset();
      pix.delete();
      for (int i = 1; i <= W * H; i++) pix.push_back(8'(i));
      push_frame(0, W, H, P, pix);
      push_prefix(0, W, P);
      wait_beats(14, 100, "t5_pre_reset_beats");
      reset = 1'b0;
      #1;
      check("t5_rst_valid", o_valid, 0);
      repeat (2) @(negedge clk);
      release_reset();
      push_frame(0, W, H, P, pix);
      push_prefix(0, W, P);
      prev_beats = 0;
      n = 0;
      while (!o_ready && n < 50) begin
         prev_beats = beats;
         @(negedge clk);
         #1;
         n++;
      end
      check("t5_ready_seen", o_ready, 1);
      check("t5_zeros_before_req", prev_beats, SW);
      wait_beats(FRAME + PREFIX, 300, "t5_beats");
      repeat (3) @(negedge clk);
      #1;
      check("t5_frames", frames, 1);

      // Wider border on a tiny image.
      pix_b.delete();
      pix_b.push_back(8'd7);
      pix_b.push_back(8'd9);
      @(negedge clk);
      #1;
      reset_b = 1'b1;
      push_frame(1, W2, H2, P2, pix_b);
      push_prefix(1, W2, P2);
      idx = 0;
      n   = 0;
      while (beats_b < FRAME2 + PREFIX2 && n < 300) begin
         @(negedge clk);
         took = b_i_valid & b_o_ready;
         @(posedge clk);
         #1;
         if (took) idx++;
         b_i_valid = idx < 2;
         b_i_x     = (idx < 2) ? pix_b[idx] : 8'd0;
         n++;
      end
      repeat (4) @(negedge clk);
      #1;
      check("t6_beats", beats_b, FRAME2 + PREFIX2);
      check("t6_inputs_taken", idx, 2);
      check("t6_frames", frames_b, 1);
      check("t6_idle_valid", b_o_valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
